// File: rtl/regfile_write_decoder.sv
// Registered one-hot write-enable decoder with burst mode and sticky range error.
// Optional macro REGFILE_WDEC_BURST_WRAP_EN: bursts wrap from the last register to 0.
module regfile_write_decoder #(
  parameter int NUM_REGS = 10,
  parameter int ADDR_W   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   WA,
  input  logic                burst_start,
  input  logic [ADDR_W-1:0]   burst_len,
  input  logic                err_clr,
  output logic [NUM_REGS-1:0] W,
  output logic                busy,
  output logic                err,
  output logic                dbg_state
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  localparam logic [ADDR_W:0]     LP_NUM  = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0]   LP_LAST = ADDR_W'(NUM_REGS - 1);
  localparam logic [NUM_REGS-1:0] LP_ONE  = NUM_REGS'(1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cur;
  logic [ADDR_W-1:0]   r_rem;
  logic [NUM_REGS-1:0] r_w;
  logic                r_busy;
  logic                r_err;

  logic              w_wa_ok;
  logic              w_last_reg;
  logic [ADDR_W-1:0] w_cur_inc;
  logic [ADDR_W-1:0] w_cur_next;
  logic              w_step_err;
  logic              w_step_more;
  logic              w_req;
  logic              w_err_set;

  assign w_wa_ok    = ({1'b0, WA} < LP_NUM);
  assign w_last_reg = (r_cur == LP_LAST);
  assign w_cur_inc  = r_cur + ADDR_W'(1);

`ifdef REGFILE_WDEC_BURST_WRAP_EN
  assign w_cur_next = w_last_reg ? '0 : w_cur_inc;
  assign w_step_err = 1'b0;
`else
  assign w_cur_next = w_cur_inc;
  // Running off the top of the bank ends the burst early and flags it.
  assign w_step_err = w_last_reg && (r_rem != '0);
`endif

  assign w_step_more = (r_rem != '0) && !w_step_err;

  // Requests (wr_en / burst_start) are only taken while busy is low; any
  // request sampled while busy is high is dropped with no other effect.
  assign w_req     = wr_en || burst_start;
  assign w_err_set = ((r_state == S_IDLE)  && w_req && !w_wa_ok) ||
                     ((r_state == S_BURST) && w_step_err);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cur   <= '0;
      r_rem   <= '0;
      r_w     <= '0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          r_w <= '0;
          if (burst_start) begin
            if (w_wa_ok) begin
              r_state <= S_BURST;
              r_busy  <= 1'b1;
              r_cur   <= WA;
              r_rem   <= burst_len;
              r_w     <= LP_ONE << WA;
            end
          end else if (wr_en && w_wa_ok) begin
            r_w <= LP_ONE << WA;
          end
        end
        S_BURST: begin
          if (w_step_more) begin
            r_cur <= w_cur_next;
            r_rem <= r_rem - ADDR_W'(1);
            r_w   <= LP_ONE << w_cur_next;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_w     <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_w     <= '0;
        end
      endcase
    end
  end

  assign W         = r_w;
  assign busy      = r_busy;
  assign err       = r_err;
  assign dbg_state = (r_state == S_BURST);

endmodule
